instr_loader: RTL and testbench

Program loader for the autoencoder core: the write side of the instruction memory that the core's program counter reads from. It takes a byte stream over a valid/ready handshake and splits it into a 16-bit program length plus N 16-bit instructions, each sent high byte first. It writes each instruction to consecutive instruction-memory addresses starting at 0. After the last word it asserts `core_run`, which releases the core's program counter. A reload can be started at any time from the finished states and stops the core first.

---
 rtl/instr_loader_if.sv | 22 ++
 rtl/instr_loader.sv | 166 ++++++++++++++++
 tb/tb_instr_loader.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/instr_loader_if.sv
// Byte-stream input and instruction-memory write port of the program loader.
// Handshake: a byte transfers on every rising clock edge where in_valid && in_ready; the source holds in_data stable until then.
interface instr_loader_if #(
    parameter int ADDR_W = 16
);
    logic              in_valid;
    logic [7:0]        in_data;
    logic              in_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [15:0]       imem_wdata;

    modport master (
        output in_valid, in_data,
        input  in_ready, imem_we, imem_addr, imem_wdata
    );

    modport slave (
        input  in_valid, in_data,
        output in_ready, imem_we, imem_addr, imem_wdata
    );
endinterface

// File: rtl/instr_loader.sv
// Program loader: byte stream -> 16-bit length + N instruction words written to imem from address 0.
// Optional INSTR_LOADER_CHECKSUM_EN adds a trailing XOR checksum byte checked in the CHK state.
module instr_loader #(
    parameter int ADDR_W = 16,
    parameter int DEPTH  = 256
) (
    input  logic          clock,
    input  logic          rst_n,
    input  logic          start,
    instr_loader_if.slave bus,
    output logic          core_run,
    output logic          busy,
    output logic          error,
    output logic [3:0]    state_dbg
);

    typedef enum logic [3:0] {
        IDLE    = 4'd0,
        LEN_HI  = 4'd1,
        LEN_LO  = 4'd2,
        DATA_HI = 4'd3,
        DATA_LO = 4'd4,
        WRITE   = 4'd5,
        CHK     = 4'd6,
        DONE    = 4'd7,
        ERROR   = 4'd8
    } state_t;

    localparam logic [16:0] DEPTH_L = 17'(DEPTH);

    state_t            state, next_state, end_state;
    logic [15:0]       length;
    logic [15:0]       count;
    logic [16:0]       count_inc;
    logic [15:0]       len_full;
    logic [7:0]        word_hi;
    logic [ADDR_W-1:0] addr;
    logic [15:0]       wdata;
    logic              in_ready_q, imem_we_q;
    logic              in_ready_d, imem_we_d, busy_d, core_run_d, error_d;
    logic              accept, load_start;

`ifdef INSTR_LOADER_CHECKSUM_EN
    logic [7:0] csum;
    assign end_state = CHK;
`else
    assign end_state = DONE;
`endif

    assign accept     = bus.in_valid && in_ready_q;
    assign load_start = start && (state inside {IDLE, DONE, ERROR});
    // Length as it will be once the low byte in flight is captured.
    assign len_full   = {length[15:8], bus.in_data};
    assign count_inc  = {1'b0, count} + 17'd1;

    assign bus.in_ready   = in_ready_q;
    assign bus.imem_we    = imem_we_q;
    assign bus.imem_addr  = addr;
    assign bus.imem_wdata = wdata;
    assign state_dbg      = state;

    // State register; all status outputs are registered from next_state.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            in_ready_q <= 1'b0;
            imem_we_q  <= 1'b0;
            busy       <= 1'b0;
            core_run   <= 1'b0;
            error      <= 1'b0;
        end else begin
            state      <= next_state;
            in_ready_q <= in_ready_d;
            imem_we_q  <= imem_we_d;
            busy       <= busy_d;
            core_run   <= core_run_d;
            error      <= error_d;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE, DONE, ERROR: if (start) next_state = LEN_HI;
            LEN_HI:  if (accept) next_state = LEN_LO;
            LEN_LO: begin
                if (accept) begin
                    if (len_full == 16'd0)               next_state = end_state;
                    else if ({1'b0, len_full} > DEPTH_L) next_state = ERROR;
                    else                                 next_state = DATA_HI;
                end
            end
            DATA_HI: if (accept) next_state = DATA_LO;
            DATA_LO: if (accept) next_state = WRITE;
            WRITE:   next_state = (count_inc < {1'b0, length}) ? DATA_HI : end_state;
`ifdef INSTR_LOADER_CHECKSUM_EN
            CHK:     if (accept) next_state = (bus.in_data == csum) ? DONE : ERROR;
`endif
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        in_ready_d = 1'b0;
        imem_we_d  = 1'b0;
        busy_d     = 1'b0;
        core_run_d = 1'b0;
        error_d    = 1'b0;
        case (next_state)
            LEN_HI, LEN_LO, DATA_HI, DATA_LO, CHK: begin
                in_ready_d = 1'b1;
                busy_d     = 1'b1;
            end
            WRITE: begin
                imem_we_d = 1'b1;
                busy_d    = 1'b1;
            end
            DONE:    core_run_d = 1'b1;
            ERROR:   error_d    = 1'b1;
            default: ;
        endcase
    end

    // Datapath: length capture, word assembly and the address/word counters.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            length  <= '0;
            count   <= '0;
            word_hi <= '0;
            addr    <= '0;
            wdata   <= '0;
        end else begin
            if (load_start) begin
                count <= '0;
                addr  <= '0;
            end
            if (accept) begin
                case (state)
                    LEN_HI:  length[15:8] <= bus.in_data;
                    LEN_LO:  length[7:0]  <= bus.in_data;
                    DATA_HI: word_hi      <= bus.in_data;
                    DATA_LO: wdata        <= {word_hi, bus.in_data};
                    default: ;
                endcase
            end
            if (state == WRITE) begin
                count <= count + 16'd1;
                addr  <= addr + 1'b1;
            end
        end
    end

`ifdef INSTR_LOADER_CHECKSUM_EN
    // Running XOR over every stream byte before the checksum byte itself.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            csum <= '0;
        end else if (load_start) begin
            csum <= '0;
        end else if (accept && state != CHK) begin
            csum <= csum ^ bus.in_data;
        end
    end
`endif

endmodule

// File: tb/tb_instr_loader.sv
// Randomized bench for instr_loader: a stream/write model plus literal directed loads.
`timescale 1ns/1ps
module tb_instr_loader;
  localparam int ADDR_W = 16;
  localparam int DEPTH  = 256;
  localparam int W      = 32;
`ifdef INSTR_LOADER_CHECKSUM_EN
  localparam bit CSUM_EN = 1'b1;
`else
  localparam bit CSUM_EN = 1'b0;
`endif

  // clock / reset
  logic clock = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic core_run, busy, error;
  logic [3:0] state_dbg;
  always #5 clock = ~clock;

  instr_loader_if #(.ADDR_W(ADDR_W)) bus();

  instr_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clock(clock), .rst_n(rst_n), .start(start), .bus(bus),
    .core_run(core_run), .busy(busy), .error(error), .state_dbg(state_dbg)
  );

  int vectors = 0;
  int miscompares = 0;
  logic [W-1:0] exp_q[$];       // {addr, data} of each expected write, in order
  logic [7:0] stream_q[$];
  logic [7:0] xor_acc;
  bit exp_err;
  int exp_lat;                  // cycles from last accepted byte to the final state
  int gap_mode;                 // 0: valid held, 1: idle cycle before each byte, 2: random idles

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // scoreboard: every write strobe must match the head of the expected queue
  always @(negedge clock) begin
    if (rst_n && bus.imem_we) begin
      check("write_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        logic [W-1:0] e;
        e = exp_q.pop_front();
        check("imem_addr", 32'(bus.imem_addr), 32'(e[31:16]));
        check("imem_wdata", 32'(bus.imem_wdata), 32'(e[15:0]));
      end
    end
  end

  // model: stream layout, expected writes and final outcome
  task automatic push_byte(input logic [7:0] b);
    stream_q.push_back(b);
    xor_acc ^= b;
  endtask

  task automatic build_load(input logic [15:0] len, input bit bad_csum);
    logic [15:0] w;
    stream_q.delete();
    xor_acc = 8'h00;
    push_byte(len[15:8]);
    push_byte(len[7:0]);
    if (len <= DEPTH) begin
      for (int i = 0; i < int'(len); i++) begin
        w = 16'($urandom);
        push_byte(w[15:8]);
        push_byte(w[7:0]);
        exp_q.push_back({16'(i), w});
      end
      if (CSUM_EN) stream_q.push_back(bad_csum ? (xor_acc ^ 8'h01) : xor_acc);
    end
    exp_err = (len > DEPTH) || (CSUM_EN && bad_csum);
    exp_lat = (!CSUM_EN && len != 0 && len <= DEPTH) ? 1 : 0;
  endtask

  // drivers
  task automatic send_byte(input logic [7:0] b);
    int waitc;
    bit acc;
    waitc = 0;
    acc = 1'b0;
    if (gap_mode == 1 || (gap_mode == 2 && $urandom_range(0, 2) == 0)) begin
      bus.in_valid = 1'b0;
      @(negedge clock);
    end
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    while (!acc && waitc < 50) begin
      acc = bus.in_ready;
      @(negedge clock);
      waitc++;
    end
    if (!acc) check("in_ready_timeout", 32'(bus.in_ready), 32'd1);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    check("busy_after_start", 32'(busy), 32'd1);
    check("in_ready_after_start", 32'(bus.in_ready), 32'd1);
    check("error_cleared", 32'(error), 32'd0);
    check("core_run_dropped", 32'(core_run), 32'd0);
  endtask

  task automatic run_stream(input bit do_start, input bit inject_start);
    if (do_start) pulse_start();
    for (int i = 0; i < stream_q.size(); i++) begin
      if (inject_start && i == 3) begin
        bus.in_valid = 1'b0;
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        check("start_ignored_busy", 32'(busy), 32'd1);
        check("start_ignored_err", 32'(error), 32'd0);
      end
      send_byte(stream_q[i]);
    end
    bus.in_valid = 1'b0;
    if (exp_lat == 1) begin
      check("core_run_early", 32'(core_run), 32'd0);
      @(negedge clock);
    end
    check("core_run", 32'(core_run), 32'(!exp_err));
    check("error", 32'(error), 32'(exp_err));
    check("busy_end", 32'(busy), 32'd0);
    check("in_ready_end", 32'(bus.in_ready), 32'd0);
    check("writes_left", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic run_load(input logic [15:0] len, input bit bad_csum, input bit do_start);
    build_load(len, bad_csum);
    run_stream(do_start, 1'b0);
  endtask

  task automatic load_literal_1234_abcd();
    logic [7:0] lit [6];
    lit = '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD};
    stream_q.delete();
    foreach (lit[i]) stream_q.push_back(lit[i]);
    if (CSUM_EN) stream_q.push_back(8'h42);
    exp_q.push_back({16'h0000, 16'h1234});
    exp_q.push_back({16'h0001, 16'hABCD});
    exp_err = 1'b0;
    exp_lat = CSUM_EN ? 0 : 1;
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    gap_mode     = 0;

    // reset state
    repeat (3) @(negedge clock);
    check("rst_in_ready", 32'(bus.in_ready), 32'd0);
    check("rst_imem_we", 32'(bus.imem_we), 32'd0);
    check("rst_core_run", 32'(core_run), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_error", 32'(error), 32'd0);
    check("rst_imem_addr", 32'(bus.imem_addr), 32'd0);
    check("rst_imem_wdata", 32'(bus.imem_wdata), 32'd0);
    rst_n = 1'b1;
    @(negedge clock);

    // two words, valid held high
    load_literal_1234_abcd();
    run_stream(1'b1, 1'b0);

    // zero length
    stream_q.delete();
    stream_q.push_back(8'h00);
    stream_q.push_back(8'h00);
    if (CSUM_EN) stream_q.push_back(8'h00);
    exp_err = 1'b0;
    exp_lat = 0;
    run_stream(1'b1, 1'b0);

    // length 0x0101 exceeds depth; start then clears error and a load follows
    stream_q.delete();
    stream_q.push_back(8'h01);
    stream_q.push_back(8'h01);
    exp_err = 1'b1;
    exp_lat = 0;
    run_stream(1'b1, 1'b0);
    pulse_start();
    run_load(16'd3, 1'b0, 1'b0);

    // valid toggled every other cycle with a start pulse mid-load
    gap_mode = 1;
    load_literal_1234_abcd();
    run_stream(1'b1, 1'b1);
    gap_mode = 0;

    // reset after three of four data bytes
    stream_q.delete();
    stream_q.push_back(8'h00);
    stream_q.push_back(8'h02);
    stream_q.push_back(8'h12);
    stream_q.push_back(8'h34);
    stream_q.push_back(8'hAB);
    exp_q.push_back({16'h0000, 16'h1234});
    pulse_start();
    foreach (stream_q[i]) send_byte(stream_q[i]);
    bus.in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("midrst_in_ready", 32'(bus.in_ready), 32'd0);
    check("midrst_imem_we", 32'(bus.imem_we), 32'd0);
    check("midrst_core_run", 32'(core_run), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_error", 32'(error), 32'd0);
    check("midrst_imem_addr", 32'(bus.imem_addr), 32'd0);
    check("midrst_imem_wdata", 32'(bus.imem_wdata), 32'd0);
    @(negedge clock);
    rst_n = 1'b1;
    @(negedge clock);
    check("midrst_writes_left", 32'(exp_q.size()), 32'd0);
    run_load(16'd2, 1'b0, 1'b1);

    // boundaries: exactly DEPTH words, and DEPTH+1
    gap_mode = 2;
    run_load(16'(DEPTH), 1'b0, 1'b1);
    run_load(16'(DEPTH + 1), 1'b0, 1'b1);

    // random loads, random flow control
    for (int n = 0; n < 24; n++) begin
      gap_mode = $urandom_range(0, 2);
      if ($urandom_range(0, 7) == 0)
        run_load(16'($urandom_range(DEPTH + 1, 65535)), 1'b0, 1'b1);
      else
        run_load(16'($urandom_range(0, 12)), CSUM_EN && ($urandom_range(0, 3) == 0), 1'b1);
    end

`ifdef INSTR_LOADER_CHECKSUM_EN
    // literal checksum cases: 00 01 12 34 xor to 27
    gap_mode = 0;
    for (int k = 0; k < 2; k++) begin
      stream_q.delete();
      stream_q.push_back(8'h00);
      stream_q.push_back(8'h01);
      stream_q.push_back(8'h12);
      stream_q.push_back(8'h34);
      stream_q.push_back(k == 0 ? 8'h27 : 8'h26);
      exp_q.push_back({16'h0000, 16'h1234});
      exp_err = (k != 0);
      exp_lat = 0;
      run_stream(1'b1, 1'b0);
    end
`endif

    repeat (2) @(negedge clock);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
